cpu_reg_access: RTL

CPU_REG_ACCESS -- requirements
Module: cpu_reg_access

---
 rtl/cpu_reg_access_pkg.sv | 17 +
 rtl/cpu_reg_access.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cpu_reg_access_pkg.sv
// Shared CPU constants and debug register-access FSM states.
// Imported by the register access block and its bench.
package cpu_reg_access_pkg;

  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_RSP,
    S_WR,
    S_WR_ACK,
    S_ERR
  } state_t;

endpackage

// File: rtl/cpu_reg_access.sv
// Debug-side burst read/write access to the CPU register file.
// Owns the regfile ports whenever a command is active.
module cpu_reg_access
  import cpu_reg_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_halted,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [REG_AW-1:0] req_addr,
  input  logic [REG_AW-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [XLEN-1:0]   wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              rf_sel,
  output logic [REG_AW-1:0] rf_rs1_addr,
  input  logic [XLEN-1:0]   rf_rs1_data,
  output logic [REG_AW-1:0] rf_rd_addr,
  output logic [XLEN-1:0]   rf_rd_data,
  output logic              rf_rd_write_en
);

  state_t            state;
  logic [REG_AW-1:0] addr;
  logic [REG_AW-1:0] cnt;
  logic [XLEN-1:0]   rdata;
  logic [REG_AW-1:0] waddr;
  logic [XLEN-1:0]   wdat;
  logic              wen;
  logic [REG_AW:0]   end_idx;

  assign end_idx = {1'b0, req_addr} + {1'b0, req_len};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      addr  <= '0;
      cnt   <= '0;
      rdata <= '0;
      waddr <= '0;
      wdat  <= '0;
      wen   <= 1'b0;
    end else begin
      wen <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (!cpu_halted ||
                end_idx > (REG_AW+1)'(NREGS-1)) begin
              state <= S_ERR;
            end else begin
              addr  <= req_addr;
              cnt   <= req_len;
              state <= req_write ? S_WR : S_RD;
            end
          end
        end
        S_RD: begin
          if (!cpu_halted) begin
            state <= S_ERR;
          end else begin
            rdata <= rf_rs1_data;
            state <= S_RD_RSP;
          end
        end
        S_RD_RSP: begin
          if (rsp_ready) begin
            if (cnt == '0) begin
              state <= S_IDLE;
            end else if (!cpu_halted) begin
              state <= S_ERR;
            end else begin
              addr  <= addr + REG_AW'(1);
              cnt   <= cnt - REG_AW'(1);
              state <= S_RD;
            end
          end
        end
        S_WR: begin
          if (!cpu_halted) begin
            state <= S_ERR;
          end else if (wdata_valid) begin
            wen   <= 1'b1;
            waddr <= addr;
            wdat  <= wdata;
            if (cnt == '0) begin
              state <= S_WR_ACK;
            end else begin
              addr <= addr + REG_AW'(1);
              cnt  <= cnt - REG_AW'(1);
            end
          end
        end
        S_WR_ACK, S_ERR: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = state == S_IDLE;
  assign rf_sel         = state != S_IDLE;
  assign wdata_ready    = (state == S_WR) && cpu_halted;
  assign rf_rs1_addr    = (state == S_RD) ? addr : '0;
  assign rsp_valid      = state inside {S_RD_RSP, S_WR_ACK, S_ERR};
  assign rsp_data       = (state == S_RD_RSP) ? rdata : '0;
  assign rsp_err        = state == S_ERR;
  // Read beats flag last from the count; ack and error are single-beat.
  assign rsp_last       = (state == S_RD_RSP) ? (cnt == '0)
                        : (state == S_WR_ACK || state == S_ERR);
  assign rf_rd_addr     = waddr;
  assign rf_rd_data     = wdat;
  assign rf_rd_write_en = wen;

endmodule
